// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-stage register/control info in, hazard
// controls and status out.
//   master : pipeline side (drives stage info, receives forwards/stalls/flushes)
//   slave  : hazard controller
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    // D / E / M / W stage information
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [1:0]       resultSrcE;
    logic             PCSrcE;
    logic [4:0]       RdM;
    logic             regWriteM;
    logic             memReqM;
    logic             memReadyM;
    logic [4:0]       RdW;
    logic             regWriteW;

    // hazard controls and status
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, PCSrcE,
               RdM, regWriteM, memReqM, memReadyM, RdW, regWriteW,
        input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, PCSrcE,
               RdM, regWriteM, memReqM, memReadyM, RdW, regWriteW,
        output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushW, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Produces E-stage forwarding selects, stall/flush enables for the pipeline
// registers, sequences multi-cycle data-memory accesses with a timeout, and
// keeps saturating stall/flush event counters.
//   clk : clock
//   rst : synchronous active-low reset
//   hz  : hazard_ctrl_if.slave (stage info in; forwards, stalls, flushes,
//         mem_err, stall_cnt, flush_cnt out)
// Forwards, stalls and flushes are combinational; mem_err and counters are
// registered.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic       mem_busy;
    logic       freeze;
    logic       lw_stall;
    logic       fwd_a_m;
    logic       fwd_a_w;
    logic       fwd_b_m;
    logic       fwd_b_w;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic       flush_w;
    logic       branch_flush;

    // Hazard conditions
    assign mem_busy = hz.memReqM & ~hz.memReadyM;
    assign freeze   = mem_busy | (state == ERR);
    assign lw_stall = (hz.resultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Forwarding matches; M beats W
    assign fwd_a_m = hz.regWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E);
    assign fwd_a_w = hz.regWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E);
    assign fwd_b_m = hz.regWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E);
    assign fwd_b_w = hz.regWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E);

    // Prioritised stall/flush/forward decode; reset flushes everything
    always_comb begin
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            if (fwd_a_m)      fwd_a = 2'b10;
            else if (fwd_a_w) fwd_a = 2'b01;
            if (fwd_b_m)      fwd_b = 2'b10;
            else if (fwd_b_w) fwd_b = 2'b01;

            if (freeze) begin
                // Hold everything up to M; bubble into W. Branch and load-use
                // are re-evaluated once the freeze lifts.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (hz.PCSrcE) begin
                // Branch kills D, so a concurrent load-use is moot
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign branch_flush = hz.PCSrcE & ~freeze;

    // Memory-wait FSM, sticky error flag and saturating event counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        if (MEM_TIMEOUT <= 1) begin
                            state     <= ERR;
                            mem_err_q <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (!hz.memReqM || hz.memReadyM) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state     <= ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (branch_flush && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.forwardAE = fwd_a;
    assign hz.forwardBE = fwd_b;
    assign hz.stallF    = stall_f;
    assign hz.stallD    = stall_d;
    assign hz.stallE    = stall_e;
    assign hz.stallM    = stall_m;
    assign hz.flushD    = flush_d;
    assign hz.flushE    = flush_e;
    assign hz.flushW    = flush_w;
    assign hz.mem_err   = mem_err_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule
